// File: rtl/prco_pipeline_ctrl.sv
// prco_pipeline_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with handshakes, HALT and RAM-timeout fault
module prco_pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  output logic             q_imem_req,
  input  logic             i_imem_ack,
  output logic             q_fetch_ce,
  output logic             q_dec_ce,
  input  logic             i_dec_reg_we,
  input  logic             i_dec_req_alu,
  input  logic             i_dec_req_ram,
  input  logic             i_dec_halt,
  output logic             q_alu_ce,
  output logic             q_ram_req,
  input  logic             i_ram_ack,
  output logic             q_rf_we,
  output logic             q_pc_inc,
  output logic [2:0]       q_state,
  output logic             q_halted,
  output logic             q_fault,
  output logic [CNT_W-1:0] q_cycle_cnt,
  output logic [CNT_W-1:0] q_retired_cnt
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
    MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ILLEGAL = 3'd7
  } state_t;
  state_t state, state_nxt;
  logic [7:0] tmo_cnt;
  logic tmo;
  // tmo_cnt holds the number of MEM cycles already spent, so this is the last allowed one
  assign tmo = tmo_cnt == 8'(MEM_TIMEOUT - 1);
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = i_en ? FETCH : IDLE;
      FETCH:   state_nxt = i_imem_ack ? DECODE : FETCH;
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = i_dec_halt ? HALT : i_dec_req_ram ? MEM : WB;
      MEM:     state_nxt = i_ram_ack ? WB : tmo ? HALT : MEM;
      WB:      state_nxt = i_en ? FETCH : IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      tmo_cnt       <= 8'd0;
      q_fault       <= 1'b0;
      q_cycle_cnt   <= '0;
      q_retired_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (state == MEM && !i_ram_ack) ? tmo_cnt + 8'd1 : 8'd0;
      if (state == MEM && tmo && !i_ram_ack) q_fault <= 1'b1;
      if (state != IDLE && state != HALT) q_cycle_cnt <= q_cycle_cnt + CNT_W'(1);
      if (state == WB) q_retired_cnt <= q_retired_cnt + CNT_W'(1);
    end
  end
  // Outputs decode from the state register so reset drops requests asynchronously
  assign q_state    = state;
  assign q_imem_req = state == FETCH;
  assign q_fetch_ce = state == FETCH && i_imem_ack;
  assign q_dec_ce   = state == DECODE;
  assign q_alu_ce   = state == EXEC && !i_dec_halt && (i_dec_req_alu || !i_dec_req_ram);
  assign q_ram_req  = state == MEM;
  assign q_rf_we    = state == WB && i_dec_reg_we;
  assign q_pc_inc   = state == WB;
  assign q_halted   = state == HALT;
endmodule

// File: tb/tb_prco_pipeline_ctrl.sv
// tb_prco_pipeline_ctrl: directed scenarios plus randomized instruction streams checked against a per-instruction cycle script
module tb_prco_pipeline_ctrl;
  localparam int T = 15;
  logic i_clk = 1'b0, i_reset_n = 1'b1, i_en = 1'b0;
  logic i_imem_ack = 1'b0, i_dec_reg_we = 1'b0, i_dec_req_alu = 1'b0;
  logic i_dec_req_ram = 1'b0, i_dec_halt = 1'b0, i_ram_ack = 1'b0;
  logic q_imem_req, q_fetch_ce, q_dec_ce, q_alu_ce, q_ram_req, q_rf_we, q_pc_inc, q_halted, q_fault;
  logic [2:0] q_state;
  logic [15:0] q_cycle_cnt, q_retired_cnt;
  int checks = 0, fails = 0;
  wire [7:0] outs = {q_imem_req, q_fetch_ce, q_dec_ce, q_alu_ce, q_ram_req, q_rf_we, q_pc_inc, q_halted};

  typedef struct packed {
    logic ack, we, alu, ram, halt, rack;
    logic [2:0] st;
    logic [7:0] outs;
  } cyc_t;

  prco_pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
    .q_imem_req(q_imem_req), .i_imem_ack(i_imem_ack), .q_fetch_ce(q_fetch_ce), .q_dec_ce(q_dec_ce),
    .i_dec_reg_we(i_dec_reg_we), .i_dec_req_alu(i_dec_req_alu), .i_dec_req_ram(i_dec_req_ram),
    .i_dec_halt(i_dec_halt), .q_alu_ce(q_alu_ce), .q_ram_req(q_ram_req), .i_ram_ack(i_ram_ack),
    .q_rf_we(q_rf_we), .q_pc_inc(q_pc_inc), .q_state(q_state), .q_halted(q_halted),
    .q_fault(q_fault), .q_cycle_cnt(q_cycle_cnt), .q_retired_cnt(q_retired_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_reset_n = 1'b0;
    {i_en, i_imem_ack, i_dec_reg_we, i_dec_req_alu, i_dec_req_ram, i_dec_halt, i_ram_ack} = '0;
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
  endtask

  task automatic drive(input cyc_t c);
    {i_imem_ack, i_dec_reg_we, i_dec_req_alu, i_dec_req_ram, i_dec_halt, i_ram_ack} =
      {c.ack, c.we, c.alu, c.ram, c.halt, c.rack};
  endtask

  task automatic test_reset;
    #1 i_reset_n = 1'b0;
    i_en = 1'b1;
    #1;
    checks++;
    if ({q_state, outs, q_fault} !== 12'd0) begin
      fails++; $display("FAIL reset_outputs: state=%0d outs=%b fault=%b, want all zero", q_state, outs, q_fault);
    end
    checks++;
    if (q_cycle_cnt !== 16'd0 || q_retired_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_counters: cyc=%0d ret=%0d, want 0/0", q_cycle_cnt, q_retired_cnt);
    end
    @(negedge i_clk);
    checks++;
    if (q_state !== 3'd0) begin
      fails++; $display("FAIL reset_hold: state=%0d, want 0", q_state);
    end
    do_reset();
  endtask

  task automatic test_movi_pair;
    logic [2:0] exp_st;
    do_reset();
    {i_en, i_imem_ack, i_dec_req_alu, i_dec_reg_we} = 4'b1111;
    step();
    for (int i = 0; i < 8; i++) begin
      exp_st = (i % 4 == 3) ? 3'd5 : 3'(i % 4 + 1);
      @(negedge i_clk);
      checks++;
      if (q_state !== exp_st || {q_rf_we, q_pc_inc} !== ((i % 4 == 3) ? 2'b11 : 2'b00)) begin
        fails++; $display("FAIL movi_cycle%0d: state=%0d rf_we/pc_inc=%b%b, want state=%0d", i + 1, q_state, q_rf_we, q_pc_inc, exp_st);
      end
      step();
    end
    checks++;
    if (q_retired_cnt !== 16'd2 || q_cycle_cnt !== 16'd8) begin
      fails++; $display("FAIL movi_counters: ret=%0d cyc=%0d, want 2/8", q_retired_cnt, q_cycle_cnt);
    end
  endtask

  task automatic test_lw_wait;
    int nreq = 0;
    logic [2:0] exp_st;
    do_reset();
    {i_en, i_imem_ack, i_dec_req_ram, i_dec_reg_we} = 4'b1111;
    step();
    for (int i = 0; i < 8; i++) begin
      i_ram_ack = (i == 6);
      if (i == 7) i_en = 1'b0;
      exp_st = i < 3 ? 3'(i + 1) : i < 7 ? 3'd4 : 3'd5;
      @(negedge i_clk);
      checks++;
      if (q_state !== exp_st) begin
        fails++; $display("FAIL lw_cycle%0d: state=%0d, want %0d", i + 1, q_state, exp_st);
      end
      if (i == 2) begin
        checks++;
        if (q_alu_ce !== 1'b0) begin
          fails++; $display("FAIL lw_alu_ce: alu_ce=%b, want 0", q_alu_ce);
        end
      end
      nreq += int'(q_ram_req);
      step();
    end
    i_ram_ack = 1'b0;
    checks++;
    if (nreq != 4 || q_fault !== 1'b0 || q_state !== 3'd0) begin
      fails++; $display("FAIL lw_summary: ram_req_cycles=%0d fault=%b state=%0d, want 4/0/0", nreq, q_fault, q_state);
    end
    checks++;
    if (q_retired_cnt !== 16'd1 || q_cycle_cnt !== 16'd8) begin
      fails++; $display("FAIL lw_counters: ret=%0d cyc=%0d, want 1/8", q_retired_cnt, q_cycle_cnt);
    end
  endtask

  task automatic test_ack_at_timeout;
    do_reset();
    {i_en, i_imem_ack, i_dec_req_ram, i_dec_reg_we} = 4'b1111;
    repeat (3 + T) step();
    i_ram_ack = 1'b1;
    @(negedge i_clk);
    checks++;
    if (q_state !== 3'd4) begin
      fails++; $display("FAIL ack_tmo_mem: state=%0d, want 4", q_state);
    end
    step();
    i_ram_ack = 1'b0;
    @(negedge i_clk);
    checks++;
    if (q_state !== 3'd5 || q_fault !== 1'b0) begin
      fails++; $display("FAIL ack_tmo_wb: state=%0d fault=%b, want 5/0", q_state, q_fault);
    end
  endtask

  task automatic test_timeout;
    int nreq = 0;
    do_reset();
    {i_en, i_imem_ack, i_dec_req_ram, i_dec_req_alu, i_dec_reg_we} = 5'b11111;
    step();
    for (int i = 0; i < 3 + T; i++) begin
      @(negedge i_clk);
      checks++;
      if (q_state !== (i < 3 ? 3'(i + 1) : 3'd4)) begin
        fails++; $display("FAIL tmo_cycle%0d: state=%0d, want %0d", i + 1, q_state, i < 3 ? i + 1 : 4);
      end
      nreq += int'(q_ram_req);
      step();
    end
    @(negedge i_clk);
    checks++;
    if (q_state !== 3'd6 || q_fault !== 1'b1 || q_halted !== 1'b1 || q_ram_req !== 1'b0 || nreq != T) begin
      fails++; $display("FAIL tmo_fault: state=%0d fault=%b halted=%b ram_req=%b req_cycles=%0d, want 6/1/1/0/%0d",
                        q_state, q_fault, q_halted, q_ram_req, nreq, T);
    end
    repeat (6) begin
      i_en = ~i_en;
      step();
    end
    checks++;
    if (q_state !== 3'd6 || q_cycle_cnt !== 16'(3 + T) || q_retired_cnt !== 16'd0) begin
      fails++; $display("FAIL tmo_frozen: state=%0d cyc=%0d ret=%0d, want 6/%0d/0", q_state, q_cycle_cnt, q_retired_cnt, 3 + T);
    end
  endtask

  task automatic test_halt;
    int nwb = 0;
    do_reset();
    {i_en, i_imem_ack, i_dec_req_alu, i_dec_reg_we, i_dec_halt} = 5'b11111;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++;
      if (q_state !== 3'(i + 1) || (i == 2 && q_alu_ce !== 1'b0)) begin
        fails++; $display("FAIL halt_cycle%0d: state=%0d alu_ce=%b, want %0d (alu_ce 0 in EXEC)", i + 1, q_state, q_alu_ce, i + 1);
      end
      nwb += int'(q_pc_inc | q_rf_we);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      i_en = 1'($urandom);
      @(negedge i_clk);
      checks++;
      if (q_state !== 3'd6 || q_halted !== 1'b1) begin
        fails++; $display("FAIL halt_stay%0d: state=%0d halted=%b, want 6/1", i, q_state, q_halted);
      end
      nwb += int'(q_pc_inc | q_rf_we);
      step();
    end
    i_dec_halt = 1'b0;
    checks++;
    if (nwb != 0 || q_retired_cnt !== 16'd0 || q_cycle_cnt !== 16'd3) begin
      fails++; $display("FAIL halt_summary: wb_pulses=%0d ret=%0d cyc=%0d, want 0/0/3", nwb, q_retired_cnt, q_cycle_cnt);
    end
  endtask

  task automatic test_en_drop;
    int npc = 0;
    logic [2:0] exp_st;
    do_reset();
    {i_en, i_imem_ack, i_dec_req_alu, i_dec_reg_we} = 4'b1111;
    step();
    step();
    i_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_st = i == 0 ? 3'd2 : i == 1 ? 3'd3 : i == 2 ? 3'd5 : 3'd0;
      @(negedge i_clk);
      checks++;
      if (q_state !== exp_st) begin
        fails++; $display("FAIL en_drop_cycle%0d: state=%0d, want %0d", i, q_state, exp_st);
      end
      npc += int'(q_pc_inc);
      step();
    end
    checks++;
    if (q_state !== 3'd0 || npc != 1) begin
      fails++; $display("FAIL en_drop_park: state=%0d pc_inc_pulses=%0d, want 0/1", q_state, npc);
    end
    i_en = 1'b1;
    step();
    checks++;
    if (q_state !== 3'd1) begin
      fails++; $display("FAIL en_resume: state=%0d, want 1", q_state);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    {i_en, i_imem_ack, i_dec_req_ram} = 3'b111;
    repeat (5) step();
    @(negedge i_clk);
    checks++;
    if (q_ram_req !== 1'b1) begin
      fails++; $display("FAIL arst_pre: ram_req=%b, want 1", q_ram_req);
    end
    #1 i_reset_n = 1'b0;
    #1;
    checks++;
    if (q_ram_req !== 1'b0 || q_state !== 3'd0 || q_cycle_cnt !== 16'd0 || q_retired_cnt !== 16'd0) begin
      fails++; $display("FAIL arst_drop: ram_req=%b state=%0d cyc=%0d ret=%0d, want 0/0/0/0", q_ram_req, q_state, q_cycle_cnt, q_retired_cnt);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    checks++;
    if (q_state !== 3'd0) begin
      fails++; $display("FAIL arst_release: state=%0d, want 0", q_state);
    end
    step();
    checks++;
    if (q_state !== 3'd1) begin
      fails++; $display("FAIL arst_restart: state=%0d, want 1", q_state);
    end
  endtask

  task automatic test_random;
    cyc_t plan[$];
    cyc_t c;
    int fw, rw;
    logic alu, ram, we;
    logic [15:0] exp_cyc = 16'd0, exp_ret = 16'd0;
    do_reset();
    i_en = 1'b1;
    step();
    for (int n = 0; n < 40; n++) begin
      fw = $urandom_range(0, 2);
      rw = $urandom_range(0, T - 1);
      {alu, ram, we} = 3'($urandom);
      plan.delete();
      for (int k = 0; k <= fw; k++) begin
        c = cyc_t'($urandom);
        c.ack = (k == fw);
        c.st = 3'd1;
        c.outs = {1'b1, c.ack, 6'b0};
        plan.push_back(c);
      end
      c = cyc_t'($urandom);
      c.st = 3'd2;
      c.outs = 8'b0010_0000;
      plan.push_back(c);
      c = '0;
      {c.alu, c.ram, c.we} = {alu, ram, we};
      c.ack = 1'($urandom);
      c.st = 3'd3;
      c.outs = {3'b000, alu | ~ram, 4'b0};
      plan.push_back(c);
      if (ram)
        for (int k = 0; k <= rw; k++) begin
          c.rack = (k == rw);
          c.st = 3'd4;
          c.outs = 8'b0000_1000;
          plan.push_back(c);
        end
      c.rack = 1'b0;
      c.st = 3'd5;
      c.outs = {5'b0, we, 2'b10};
      plan.push_back(c);
      foreach (plan[j]) begin
        drive(plan[j]);
        @(negedge i_clk);
        checks++;
        if ({q_state, outs} !== {plan[j].st, plan[j].outs} || q_cycle_cnt !== exp_cyc || q_retired_cnt !== exp_ret) begin
          fails++;
          $display("FAIL rand_instr%0d_cyc%0d: state=%0d outs=%b cyc=%0d ret=%0d, want state=%0d outs=%b cyc=%0d ret=%0d",
                   n, j, q_state, outs, q_cycle_cnt, q_retired_cnt, plan[j].st, plan[j].outs, exp_cyc, exp_ret);
        end
        exp_cyc++;
        if (plan[j].st == 3'd5) exp_ret++;
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_movi_pair();
    test_lw_wait();
    test_ack_at_timeout();
    test_timeout();
    test_halt();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
